// File: rtl/fetch_tgen_pkg.sv
// Shared types and constants for the fetch traffic generator.
// Mode/state encodings and the Galois LFSR used for RANDOM addressing.
package fetch_tgen_pkg;

  typedef enum logic [1:0] {
    MODE_SEQ    = 2'd0,
    MODE_STRIDE = 2'd1,
    MODE_RANDOM = 2'd2,
    MODE_LOOP   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam int          LOOP_LEN  = 8;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/fetch_tgen_chan.sv
// One fetch channel: FSM, address pattern, in-flight address FIFO and response checker.
// req drops while the FIFO is full unless a response frees a slot in the same cycle.
module fetch_tgen_chan
  import fetch_tgen_pkg::*;
#(
  parameter int          AW         = 32,
  parameter int          DW         = 32,
  parameter int          MAX_OUT    = 4,
  parameter int          RANGE_LOG2 = 12,
  parameter logic [AW-1:0] BASE     = '0,
  parameter logic [31:0] SEED       = 32'h1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [15:0]   stride,
  input  logic [15:0]   nb_trans,
  output logic          req,
  output logic [AW-1:0] addr,
  input  logic          gnt,
  input  logic          rvalid,
  input  logic [DW-1:0] rdata,
  output logic          err,
  output logic          rsp,
  output logic          busy,
  output logic          done
);

  localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CW = $clog2(MAX_OUT + 1);
  localparam int LW = $clog2(LOOP_LEN);

  state_e                state_q, state_d;
  mode_e                 mode_q;
  logic [15:0]           stride_q, nb_q, gnt_cnt_q;
  logic [RANGE_LOG2-1:0] off_q, off_d, sum_off, step;
  logic [31:0]           lfsr_q, lfsr_nxt;
  logic [LW-1:0]         loop_q;
  logic [DW-1:0]         mem_q [MAX_OUT];
  logic [PW-1:0]         wr_q, rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  full, empty, push, pop, start_ok;

  assign full     = (cnt_q == CW'(MAX_OUT));
  assign empty    = (cnt_q == '0);
  assign pop      = rvalid & ~empty;
  assign req      = (state_q == ST_RUN) & (~full | pop);
  assign push     = req & gnt;
  assign addr     = BASE + AW'(off_q);
  assign start_ok = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));

  // A response with nothing outstanding is a protocol error and never pops.
  assign err  = (rvalid & empty) | (pop & (mem_q[rd_q] != rdata));
  assign rsp  = pop;
  assign busy = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

  always_comb begin
    lfsr_nxt = lfsr_step(lfsr_q);
    sum_off  = off_q + RANGE_LOG2'(stride_q);
    case (mode_q)
      MODE_SEQ:    step = off_q + RANGE_LOG2'(4);
      MODE_STRIDE: step = sum_off;
      MODE_RANDOM: step = RANGE_LOG2'(lfsr_nxt);
      MODE_LOOP:   step = (loop_q == LW'(LOOP_LEN - 1)) ? '0 : sum_off;
      default:     step = sum_off;
    endcase
    off_d = step & ~RANGE_LOG2'(3);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = (nb_trans == 16'd0) ? ST_DONE : ST_RUN;
      ST_RUN:           if (push && (gnt_cnt_q + 16'd1 == nb_q)) state_d = ST_DRAIN;
      ST_DRAIN:         if (empty) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_SEQ;
      stride_q  <= '0;
      nb_q      <= '0;
      gnt_cnt_q <= '0;
      off_q     <= '0;
      lfsr_q    <= SEED;
      loop_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mode_q    <= mode_e'(mode);
        stride_q  <= {stride[15:2], 2'b00};
        nb_q      <= nb_trans;
        gnt_cnt_q <= '0;
        off_q     <= '0;
        lfsr_q    <= SEED;
        loop_q    <= '0;
      end else if (push) begin
        gnt_cnt_q <= gnt_cnt_q + 16'd1;
        off_q     <= off_d;
        lfsr_q    <= lfsr_nxt;
        loop_q    <= (loop_q == LW'(LOOP_LEN - 1)) ? '0 : loop_q + LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= addr[DW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == PW'(MAX_OUT - 1)) ? '0 : wr_q + PW'(1);
      if (pop)  rd_q <= (rd_q == PW'(MAX_OUT - 1)) ? '0 : rd_q + PW'(1);
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: rtl/fetch_tgen_mc.sv
// Multi-channel fetch traffic generator with global start/done and error/transaction totals.
// Starts are ignored while any channel is busy; err_cnt_o saturates, trans_cnt_o wraps.
module fetch_tgen_mc
  import fetch_tgen_pkg::*;
#(
  parameter int                          NB_CH            = 2,
  parameter int                          FETCH_ADDR_WIDTH = 32,
  parameter int                          FETCH_DATA_WIDTH = 32,
  parameter int                          MAX_OUTSTANDING  = 4,
  parameter logic [FETCH_ADDR_WIDTH-1:0] BASE_ADDR        = 32'h1C00_0000,
  parameter int                          RANGE_LOG2       = 12,
  parameter logic [31:0]                 LFSR_SEED        = 32'hACE1_2468
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start_i,
  input  logic [1:0]                           mode_i,
  input  logic [15:0]                          stride_i,
  input  logic [15:0]                          nb_trans_i,
  output logic [NB_CH-1:0]                     fetch_req_o,
  output logic [NB_CH*FETCH_ADDR_WIDTH-1:0]    fetch_addr_o,
  input  logic [NB_CH-1:0]                     fetch_gnt_i,
  input  logic [NB_CH-1:0]                     fetch_rvalid_i,
  input  logic [NB_CH*FETCH_DATA_WIDTH-1:0]    fetch_rdata_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic [15:0]                          err_cnt_o,
  output logic [31:0]                          trans_cnt_o
);

  logic [NB_CH-1:0] ch_err, ch_rsp, ch_busy, ch_done;
  logic             start_acc, done_q;
  logic [15:0]      err_cnt_q;
  logic [31:0]      trans_cnt_q, n_err, n_rsp;
  logic [16:0]      err_sum;

  assign busy_o    = |ch_busy;
  assign start_acc = start_i & ~busy_o;

  for (genvar c = 0; c < NB_CH; c++) begin : g_ch
    localparam logic [FETCH_ADDR_WIDTH-1:0] CH_BASE =
      BASE_ADDR + (FETCH_ADDR_WIDTH'(c) << RANGE_LOG2);

    fetch_tgen_chan #(
      .AW         (FETCH_ADDR_WIDTH),
      .DW         (FETCH_DATA_WIDTH),
      .MAX_OUT    (MAX_OUTSTANDING),
      .RANGE_LOG2 (RANGE_LOG2),
      .BASE       (CH_BASE),
      .SEED       (LFSR_SEED ^ 32'(c))
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .start    (start_acc),
      .mode     (mode_i),
      .stride   (stride_i),
      .nb_trans (nb_trans_i),
      .req      (fetch_req_o[c]),
      .addr     (fetch_addr_o[c*FETCH_ADDR_WIDTH +: FETCH_ADDR_WIDTH]),
      .gnt      (fetch_gnt_i[c]),
      .rvalid   (fetch_rvalid_i[c]),
      .rdata    (fetch_rdata_i[c*FETCH_DATA_WIDTH +: FETCH_DATA_WIDTH]),
      .err      (ch_err[c]),
      .rsp      (ch_rsp[c]),
      .busy     (ch_busy[c]),
      .done     (ch_done[c])
    );
  end

  always_comb begin
    n_err = '0;
    n_rsp = '0;
    for (int c = 0; c < NB_CH; c++) begin
      n_err = n_err + 32'(ch_err[c]);
      n_rsp = n_rsp + 32'(ch_rsp[c]);
    end
    err_sum = {1'b0, err_cnt_q} + 17'(n_err);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q      <= 1'b0;
      err_cnt_q   <= '0;
      trans_cnt_q <= '0;
    end else begin
      done_q      <= start_acc ? 1'b0 : &ch_done;
      err_cnt_q   <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
      trans_cnt_q <= trans_cnt_q + n_rsp;
    end
  end

  assign done_o      = done_q;
  assign err_cnt_o   = err_cnt_q;
  assign trans_cnt_o = trans_cnt_q;

endmodule

// File: tb/tb_fetch_tgen_mc.sv
// Scoreboard bench: expected fetch addresses are queued per channel, a monitor checks each grant;
// a memory model returns address-pattern data with configurable latency and fault injection.
module tb_fetch_tgen_mc;

  localparam int NB = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        mode_i = '0;
  logic [15:0]       stride_i = '0;
  logic [15:0]       nb_trans_i = '0;
  logic [NB-1:0]     fetch_req_o;
  logic [NB*AW-1:0]  fetch_addr_o;
  logic [NB-1:0]     fetch_gnt_i = '0;
  logic [NB-1:0]     fetch_rvalid_i = '0;
  logic [NB*DW-1:0]  fetch_rdata_i = '0;
  logic              busy_o, done_o;
  logic [15:0]       err_cnt_o;
  logic [31:0]       trans_cnt_o;

  fetch_tgen_mc dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .mode_i         (mode_i),
    .stride_i       (stride_i),
    .nb_trans_i     (nb_trans_i),
    .fetch_req_o    (fetch_req_o),
    .fetch_addr_o   (fetch_addr_o),
    .fetch_gnt_i    (fetch_gnt_i),
    .fetch_rvalid_i (fetch_rvalid_i),
    .fetch_rdata_i  (fetch_rdata_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_cnt_o      (err_cnt_o),
    .trans_cnt_o    (trans_cnt_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  int          n_checks = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          run_id = 0;
  int          start_cyc = 0;
  int          gnt_mode = 1;
  int          lat_min = 1;
  int          lat_max = 1;
  int          spur_req = 0;
  int          corrupt_at [NB] = '{-1, -1};
  logic [31:0] expq [NB][$];

  // memory-model state (driver only)
  rsp_t        memq [NB][$];
  int          last_due [NB] = '{0, 0};
  int          gcount [NB] = '{0, 0};
  int          drv_id = 0;
  int          spur_done = 0;

  // monitor state (monitor only)
  int          mon_id = 0;
  int          infl [NB] = '{0, 0};
  int          max_infl [NB] = '{0, 0};
  int          hs_cnt [NB] = '{0, 0};
  int          first_hs [NB] = '{-1, -1};
  int          ev_fullpp = 0;

  function automatic logic [31:0] ch_base(input int c);
    return 32'h1C00_0000 + 32'(c) * 32'h1000;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // memory model: in-order responses, latency lat_min..lat_max after the grant
  always @(negedge clk) begin : drv
    if (drv_id != run_id) begin
      drv_id = run_id;
      for (int c = 0; c < NB; c++) gcount[c] = 0;
    end
    for (int c = 0; c < NB; c++) begin
      if (!rst && memq[c].size() > 0 && memq[c][0].due <= cyc) begin
        fetch_rvalid_i[c]          = 1'b1;
        fetch_rdata_i[c*DW +: DW]  = memq[c][0].data;
        void'(memq[c].pop_front());
      end else if (!rst && c == 0 && spur_req > spur_done) begin
        fetch_rvalid_i[c]          = 1'b1;
        fetch_rdata_i[c*DW +: DW]  = '0;
        spur_done++;
      end else begin
        fetch_rvalid_i[c]          = 1'b0;
        fetch_rdata_i[c*DW +: DW]  = '0;
      end
    end
    #1;
    for (int c = 0; c < NB; c++)
      fetch_gnt_i[c] = (gnt_mode == 1) ? 1'b1 :
                       (gnt_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    for (int c = 0; c < NB; c++) begin : push_rsp
      rsp_t r;
      if (!rst && fetch_req_o[c] && fetch_gnt_i[c]) begin
        r.data = fetch_addr_o[c*AW +: AW];
        if (gcount[c] == corrupt_at[c]) r.data = r.data ^ 32'h1;
        gcount[c]++;
        r.due = cyc + int'($urandom_range(lat_min, lat_max));
        if (r.due <= last_due[c]) r.due = last_due[c] + 1;
        last_due[c] = r.due;
        memq[c].push_back(r);
      end
    end
  end

  // monitor: checks every granted address against the expected queue
  always @(negedge clk) begin : mon
    #3;
    if (mon_id != run_id) begin
      mon_id    = run_id;
      ev_fullpp = 0;
      for (int c = 0; c < NB; c++) begin
        max_infl[c] = 0;
        first_hs[c] = -1;
      end
    end
    if (rst) begin
      for (int c = 0; c < NB; c++) infl[c] = 0;
    end else begin
      for (int c = 0; c < NB; c++) begin : per_ch
        bit          p_push, p_pop;
        logic [31:0] e;
        p_push = fetch_req_o[c] & fetch_gnt_i[c];
        p_pop  = fetch_rvalid_i[c] && (infl[c] > 0);
        if (p_push && p_pop && infl[c] == 4) ev_fullpp++;
        if (p_push) begin
          hs_cnt[c]++;
          if (first_hs[c] < 0) first_hs[c] = cyc;
          if (expq[c].size() == 0) begin
            n_checks++;
            $display("FAIL ch%0d extra req: got addr 0x%0h, expected no request", c,
                     fetch_addr_o[c*AW +: AW]);
          end else begin
            e = expq[c].pop_front();
            chk($sformatf("ch%0d addr", c), 64'(fetch_addr_o[c*AW +: AW]), 64'(e));
          end
        end
        infl[c] = infl[c] + (p_push ? 1 : 0) - (p_pop ? 1 : 0);
        if (infl[c] > max_infl[c]) max_infl[c] = infl[c];
      end
    end
  end

  task automatic start_run(input logic [1:0] m, input logic [15:0] s, input logic [15:0] n);
    @(negedge clk);
    mode_i     = m;
    stride_i   = s;
    nb_trans_i = n;
    start_i    = 1'b1;
    start_cyc  = cyc;
    run_id++;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk({name, " done"}, 64'(done_o), 64'd1);
  endtask

  task automatic end_checks(input string name, input int exp_err, input int exp_trans);
    chk({name, " err"}, 64'(err_cnt_o), 64'(exp_err));
    chk({name, " trans"}, 64'(trans_cnt_o), 64'(exp_trans));
    chk({name, " busy"}, 64'(busy_o), 64'd0);
    for (int c = 0; c < NB; c++)
      chk($sformatf("%s ch%0d expected addrs left", name, c), 64'(expq[c].size()), 64'd0);
  endtask

  // offs holds hand-computed LFSR-derived offsets for both channels
  logic [31:0] rnd_offs [5] = '{32'h000, 32'h234, 32'h918, 32'h48C, 32'h244};

  initial begin : timeout
    #600000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int pend;
    int hs_before;

    // reset values
    @(negedge clk);
    chk("rst req", 64'(fetch_req_o), 64'd0);
    chk("rst addr", 64'(fetch_addr_o), {32'h1C00_1000, 32'h1C00_0000});
    chk("rst busy", 64'(busy_o), 64'd0);
    chk("rst done", 64'(done_o), 64'd0);
    chk("rst err", 64'(err_cnt_o), 64'd0);
    chk("rst trans", 64'(trans_cnt_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // SEQ, 16 each, gnt tied high, 1-cycle memory
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 16; i++) expq[c].push_back(ch_base(c) + 32'(4 * i));
    start_run(2'd0, 16'd0, 16'd16);
    wait_done("seq", 200);
    chk("seq first req latency", 64'(first_hs[0] - start_cyc), 64'd1);
    end_checks("seq", 0, 32);

    // STRIDE 0x100, 20 each: offset wraps 0xF00 -> 0x000
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 20; i++) expq[c].push_back(ch_base(c) + 32'((i * 32'h100) % 32'h1000));
    start_run(2'd1, 16'h0100, 16'd20);
    wait_done("stride", 300);
    end_checks("stride", 0, 72);

    // LOOP stride 0x10 (low bits 3 ignored), fixed latency 4 so the FIFO fills
    lat_min = 4; lat_max = 4;
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 20; i++) expq[c].push_back(ch_base(c) + 32'((i % 8) * 32'h10));
    start_run(2'd3, 16'h0013, 16'd20);
    wait_done("loop", 300);
    chk("loop push+pop on full seen", 64'(ev_fullpp > 0), 64'd1);
    end_checks("loop", 0, 112);

    // random grant, latency 1..8
    gnt_mode = 2; lat_min = 1; lat_max = 8;
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 40; i++) expq[c].push_back(ch_base(c) + 32'(4 * i));
    start_run(2'd0, 16'd0, 16'd40);
    wait_done("rgnt", 3000);
    for (int c = 0; c < NB; c++)
      chk($sformatf("rgnt ch%0d max in flight <= 4", c), 64'(max_infl[c] <= 4), 64'd1);
    end_checks("rgnt", 0, 192);

    // RANDOM mode, offsets from the seeded LFSR
    gnt_mode = 1; lat_min = 1; lat_max = 1;
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 5; i++) expq[c].push_back(ch_base(c) + rnd_offs[i]);
    start_run(2'd2, 16'd0, 16'd5);
    wait_done("rand", 200);
    end_checks("rand", 0, 202);

    // one corrupted word on channel 1
    corrupt_at[1] = 3;
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 8; i++) expq[c].push_back(ch_base(c) + 32'(4 * i));
    start_run(2'd0, 16'd0, 16'd8);
    wait_done("corrupt", 200);
    end_checks("corrupt", 1, 218);
    corrupt_at[1] = -1;

    // spurious response with nothing outstanding
    @(posedge clk); spur_req++;
    repeat (4) @(negedge clk);
    chk("spur err", 64'(err_cnt_o), 64'd2);
    chk("spur trans", 64'(trans_cnt_o), 64'd218);

    // nb_trans = 0: done drops on accept, returns next cycle, no request
    hs_before = hs_cnt[0] + hs_cnt[1];
    start_run(2'd0, 16'd0, 16'd0);
    chk("nb0 done cleared", 64'(done_o), 64'd0);
    @(negedge clk);
    chk("nb0 done", 64'(done_o), 64'd1);
    chk("nb0 no req", 64'(hs_cnt[0] + hs_cnt[1] - hs_before), 64'd0);
    chk("nb0 trans", 64'(trans_cnt_o), 64'd218);

    // start while busy is ignored
    gnt_mode = 0;
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 16; i++) expq[c].push_back(ch_base(c) + 32'(4 * i));
    start_run(2'd0, 16'd0, 16'd16);
    repeat (3) @(negedge clk);
    chk("busy during run", 64'(busy_o), 64'd1);
    mode_i = 2'd1; stride_i = 16'h0100; nb_trans_i = 16'd3; start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    gnt_mode = 1;
    wait_done("busy-start", 300);
    end_checks("busy-start", 2, 250);

    // reset mid-RUN; stale responses afterwards are protocol errors
    lat_min = 8; lat_max = 8;
    for (int c = 0; c < NB; c++)
      for (int i = 0; i < 16; i++) expq[c].push_back(ch_base(c) + 32'(4 * i));
    start_run(2'd0, 16'd0, 16'd16);
    repeat (6) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    pend = memq[0].size() + memq[1].size();
    for (int c = 0; c < NB; c++) expq[c].delete();
    @(negedge clk);
    chk("mid-rst req", 64'(fetch_req_o), 64'd0);
    chk("mid-rst addr", 64'(fetch_addr_o), {32'h1C00_1000, 32'h1C00_0000});
    chk("mid-rst busy", 64'(busy_o), 64'd0);
    chk("mid-rst done", 64'(done_o), 64'd0);
    chk("mid-rst err", 64'(err_cnt_o), 64'd0);
    chk("mid-rst trans", 64'(trans_cnt_o), 64'd0);
    chk("mid-rst pending responses", 64'(pend > 0), 64'd1);
    @(posedge clk); #1 rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("post-rst stale rsp err", 64'(err_cnt_o), 64'(pend));
    chk("post-rst trans", 64'(trans_cnt_o), 64'd0);
    chk("post-rst req", 64'(fetch_req_o), 64'd0);
    chk("post-rst done", 64'(done_o), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_tgen_mc.md
# fetch_tgen_mc

Multi-channel, self-checking instruction-fetch traffic generator for icache bank benches and bring-up. Each channel drives one core-side fetch port (req/addr/gnt/rvalid/rdata) with a programmable address pattern. Each channel holds up to MAX_OUTSTANDING requests in flight. Each channel checks every returned word against an address-derived expected value and counts errors. A bench instantiates one generator per cache under test and reads the done/error outputs instead of relying on `$error` assertions.

## Interface

Parameters:
- NB_CH, 2, number of independent fetch channels
- FETCH_ADDR_WIDTH, 32, fetch address width
- FETCH_DATA_WIDTH, 32, fetch data width (≤ FETCH_ADDR_WIDTH)
- MAX_OUTSTANDING, 4, in-flight requests per channel (power of 2, ≥1)
- BASE_ADDR, 32'h1C00_0000, channel 0 region base
- RANGE_LOG2, 12, per-channel region size in bytes (log2)
- LFSR_SEED, 32'hACE1_2468, random-mode seed (channel c uses SEED ^ c)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse; starts all channels when idle
- mode_i  in  2  0 SEQ, 1 STRIDE, 2 RANDOM, 3 LOOP; sampled at start
- stride_i  in  16  byte stride for STRIDE/LOOP, sampled at start; low 2 bits ignored
- nb_trans_i  in  16  requests per channel, sampled at start; 0 = done immediately
- fetch_req_o  out  NB_CH  per-channel request
- fetch_addr_o  out  NB_CH*FETCH_ADDR_WIDTH  per-channel word-aligned address
- fetch_gnt_i  in  NB_CH  grant
- fetch_rvalid_i  in  NB_CH  response valid
- fetch_rdata_i  in  NB_CH*FETCH_DATA_WIDTH  response data
- busy_o  out  1  any channel not IDLE/DONE
- done_o  out  1  all channels DONE
- err_cnt_o  out  16  saturating total of data and protocol errors
- trans_cnt_o  out  32  total completed responses, all channels

## Operation

- Channel base: BASE_ADDR + (c << RANGE_LOG2). Offsets wrap modulo 2^RANGE_LOG2 and are forced word-aligned.
- Address step after each grant:
  - SEQ: +4.
  - STRIDE: +stride.
  - RANDOM: offset = 32-bit Galois LFSR (taps 32,22,2,1) masked to the range; the LFSR advances once per grant.
  - LOOP: +stride, except that every 8th grant returns to the base.
- Expected rdata = low FETCH_DATA_WIDTH bits of the request address. The memory image is filled with an address pattern.
- Each channel keeps an address FIFO of depth MAX_OUTSTANDING. The address is pushed on req&gnt and popped on rvalid. On rvalid, popped address ≠ rdata → err +1.
- rvalid with an empty FIFO is a protocol error: err +1, no pop.
- Channel FSM (fetch_tgen_pkg::state_e):
  - IDLE→RUN on start_i (IDLE→DONE if nb_trans_i==0).
  - RUN→DRAIN when the granted count reaches nb_trans.
  - DRAIN→DONE when the FIFO is empty.
  - DONE→RUN on a new start_i.
- start_i while busy_o is ignored.

## Timing

- Reset values: fetch_req_o 0, fetch_addr_o = channel base, busy_o 0, done_o 0, err_cnt_o 0, trans_cnt_o 0. FIFOs and counters clear and FSMs go to IDLE.
- Reset mid-operation abandons all in-flight requests. Responses arriving after reset release count as protocol errors.
- req rises the cycle after start_i, with the address at the base.
- req and addr are held stable until gnt. The next address appears in the cycle after req&gnt.
- Back-to-back grants sustain one request per cycle per channel.
- req is deasserted while the FIFO is full, except when a pop occurs in the same cycle: simultaneous push and pop on a full FIFO is legal and the count is unchanged.
- Response may arrive the cycle after gnt at the earliest. A grant and an unrelated response in the same cycle are both handled.
- done_o asserts the cycle after the last channel enters DONE. It clears on the next accepted start_i.
- err_cnt_o saturates at 16'hFFFF.
- trans_cnt_o increments by the number of channels with rvalid in that cycle. It wraps naturally.

## Structure

- fetch_tgen_pkg: mode_e, state_e, LFSR polynomial constant, LOOP_LEN=8.
- Sub-module fetch_tgen_chan: one channel, containing the FSM, address generator, LFSR, FIFO and checker. Its outputs are an error pulse, a response pulse and a done flag.
- Top level: NB_CH chan instances, the start/busy/done logic, and the global error/transaction accumulators.

## Test plan

- SEQ, nb_trans=16, gnt tied 1, 1-cycle memory → channel 0 addresses 1C00_0000..1C00_003C step 4; done_o set; err 0; trans_cnt 32.
- STRIDE 0x100, RANGE_LOG2=12, nb_trans=20 → address wraps from 1C00_0F00 to 1C00_0000; err 0.
- Random gnt (50%) with response latency 1–8 cycles, MAX_OUTSTANDING=4 → never more than 4 in flight (req low while full); simultaneous push/pop on full is exercised; err 0.
- Memory corrupts one word (rdata ^ 1) → err_cnt_o == 1 exactly; done still reached.
- Spurious rvalid with no request outstanding → err +1, trans_cnt unchanged in the FIFO sense; reset asserted mid-RUN → all outputs return to reset values next cycle.
- nb_trans=0 start → done_o next cycle, no req; start_i during busy → ignored, counts unaffected.
